// File: rtl/flash_pkg.sv
// ---------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the byte-mode parallel flash word reader:
//   - FL_ADDR_W                 flash byte-address width
//   - FL_ACCESS_CYCLES_DEF      default clocks per flash byte access
//   - FL_RST_HOLD_CYCLES_DEF    default clocks oFL_RST_N is held low
//   - fl_state_e                reader FSM state encoding
//   - fl_word_base()            even (word-aligned) byte address of a request
// ---------------------------------------------------------------------------
package flash_pkg;

    localparam int FL_ADDR_W              = 23;
    localparam int FL_ACCESS_CYCLES_DEF   = 6;
    localparam int FL_RST_HOLD_CYCLES_DEF = 32;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ACC_HI   = 3'd2,
        ST_ACC_LO   = 3'd3,
        ST_DONE     = 3'd4
    } fl_state_e;

    // Word reads always start on the even byte; bit 0 of the request is ignored.
    function automatic logic [FL_ADDR_W-1:0] fl_word_base(input logic [FL_ADDR_W-1:0] addr);
        return addr & ~FL_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/flash_word_reader_if.sv
// ---------------------------------------------------------------------------
// flash_word_reader_if
// Toggle-handshake request bus between a requester and flash_word_reader.
//   ifl_addr  [22:0]  byte address of the requested word (bit 0 ignored)
//   ifl_req           toggle request: a new request exists while ifl_req != ofl_ack
//   ofl_ack           toggle acknowledge: follows ifl_req once the word is valid
//   ofl_data  [15:0]  read word, held until the next completion
// Modports: master = requester side, slave = flash_word_reader side.
// ---------------------------------------------------------------------------
interface flash_word_reader_if;
    import flash_pkg::*;

    logic [FL_ADDR_W-1:0] ifl_addr;
    logic                 ifl_req;
    logic                 ofl_ack;
    logic [15:0]          ofl_data;

    modport master (
        output ifl_addr,
        output ifl_req,
        input  ofl_ack,
        input  ofl_data
    );

    modport slave (
        input  ifl_addr,
        input  ifl_req,
        output ofl_ack,
        output ofl_data
    );

endinterface

// File: rtl/flash_word_reader.sv
// ---------------------------------------------------------------------------
// flash_word_reader
// Reads one 16-bit word from a byte-mode parallel flash as two byte accesses
// (even byte, then odd byte) on a toggle request/acknowledge handshake.
//
// Parameters:
//   ACCESS_CYCLES    clocks per flash byte access (2..15)
//   RST_HOLD_CYCLES  clocks oFL_RST_N is held low after reset release (1..255)
// Ports:
//   iclk       sole clock, rising edge
//   ireset     synchronous active-high reset
//   bus        flash_word_reader_if.slave (ifl_addr, ifl_req, ofl_ack, ofl_data)
//   oFL_ADDR   flash byte address pins
//   iFL_DQ     flash data pins (byte mode)
//   oFL_CE_N, oFL_OE_N, oFL_WE_N, oFL_RST_N, oFL_WP_N  active-low flash controls
// Build option:
//   FLASH_BYTE_SWAP_EN  when defined, the even byte lands in ofl_data[7:0] and
//                       the odd byte in ofl_data[15:8]; otherwise big-endian.
//
// Timing: the request is detected on an IDLE edge; the even address is driven
// for ACCESS_CYCLES clocks, the odd address for ACCESS_CYCLES clocks, then the
// flash is deselected for two clocks (output-disable recovery) before ofl_data
// and ofl_ack update together: 2*ACCESS_CYCLES+2 clocks after detection.
// ---------------------------------------------------------------------------
module flash_word_reader
    import flash_pkg::*;
#(
    parameter int ACCESS_CYCLES   = FL_ACCESS_CYCLES_DEF,
    parameter int RST_HOLD_CYCLES = FL_RST_HOLD_CYCLES_DEF
) (
    input  logic                  iclk,
    input  logic                  ireset,
    flash_word_reader_if.slave    bus,
    output logic [FL_ADDR_W-1:0]  oFL_ADDR,
    input  logic [7:0]            iFL_DQ,
    output logic                  oFL_CE_N,
    output logic                  oFL_OE_N,
    output logic                  oFL_WE_N,
    output logic                  oFL_RST_N,
    output logic                  oFL_WP_N
);

    localparam logic [7:0] ACC_LAST  = 8'(ACCESS_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);
    localparam logic [7:0] DONE_LAST = 8'd1;

    fl_state_e            r_state;
    logic [7:0]           r_cnt;
    logic [FL_ADDR_W-1:0] r_addr;
    logic                 r_req;
    logic [7:0]           r_hi;
    logic [7:0]           r_lo;
    logic                 r_ack;
    logic [15:0]          r_data;
    logic [FL_ADDR_W-1:0] r_fl_addr;
    logic                 r_ce_n;
    logic                 r_oe_n;
    logic                 r_rst_n;
    logic [15:0]          w_word;

`ifdef FLASH_BYTE_SWAP_EN
    assign w_word = {r_lo, r_hi};
`else
    assign w_word = {r_hi, r_lo};
`endif

    // Reader FSM: reset hold, request capture, two byte accesses, completion.
    // Flash pins are registered and updated on the same edge as the state
    // transition so they are valid for the whole duration of each state.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state   <= ST_RST_HOLD;
            r_cnt     <= 8'd0;
            r_addr    <= '0;
            r_req     <= 1'b0;
            r_hi      <= 8'd0;
            r_lo      <= 8'd0;
            r_ack     <= 1'b0;
            r_data    <= 16'd0;
            r_fl_addr <= '0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_rst_n   <= 1'b0;
        end else begin
            case (r_state)
                ST_RST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= 8'd0;
                        r_rst_n <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (bus.ifl_req != r_ack) begin
                        r_addr    <= fl_word_base(bus.ifl_addr);
                        r_fl_addr <= fl_word_base(bus.ifl_addr);
                        r_req     <= bus.ifl_req;
                        r_ce_n    <= 1'b0;
                        r_oe_n    <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_state   <= ST_ACC_HI;
                    end else begin
                        r_cnt <= 8'd0;
                    end
                end
                ST_ACC_HI: begin
                    if (r_cnt == ACC_LAST) begin
                        r_hi      <= iFL_DQ;
                        r_fl_addr <= r_addr | FL_ADDR_W'(1);
                        r_cnt     <= 8'd0;
                        r_state   <= ST_ACC_LO;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_ACC_LO: begin
                    if (r_cnt == ACC_LAST) begin
                        r_lo    <= iFL_DQ;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    // Data and ack move on the same edge so the requester never
                    // sees an ack ahead of its word.
                    if (r_cnt == DONE_LAST) begin
                        r_data  <= w_word;
                        r_ack   <= r_req;
                        r_cnt   <= 8'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_cnt   <= 8'd0;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_rst_n <= 1'b0;
                    r_state <= ST_RST_HOLD;
                end
            endcase
        end
    end

    assign bus.ofl_ack  = r_ack;
    assign bus.ofl_data = r_data;
    assign oFL_ADDR     = r_fl_addr;
    assign oFL_CE_N     = r_ce_n;
    assign oFL_OE_N     = r_oe_n;
    assign oFL_RST_N    = r_rst_n;
    // Read-only controller: the flash is never written or unprotected.
    assign oFL_WE_N     = 1'b1;
    assign oFL_WP_N     = 1'b1;

endmodule

// File: tb/tb_flash_word_reader.sv
// ---------------------------------------------------------------------------
// tb_flash_word_reader
// Randomized scoreboard bench for flash_word_reader. A behavioural flash
// (byte lookup function) drives iFL_DQ; the driver pushes the expected word
// and issue cycle for each request, and a negedge monitor pops and compares
// whenever ofl_ack toggles.
// ---------------------------------------------------------------------------
module tb_flash_word_reader;
    import flash_pkg::*;

    localparam int AC   = FL_ACCESS_CYCLES_DEF;
    localparam int HOLD = FL_RST_HOLD_CYCLES_DEF;
    // Request toggled on a negedge, detected on the next posedge, ack 2*AC+2
    // posedges later, observed on the negedge after that.
    localparam int OBS_LAT = 2 * AC + 3;

    logic        iclk   = 1'b0;
    logic        ireset = 1'b1;
    logic [22:0] oFL_ADDR;
    logic [7:0]  iFL_DQ;
    logic        oFL_CE_N, oFL_OE_N, oFL_WE_N, oFL_RST_N, oFL_WP_N;

    flash_word_reader_if bus();

    flash_word_reader #(.ACCESS_CYCLES(AC), .RST_HOLD_CYCLES(HOLD)) dut (
        .iclk      (iclk),
        .ireset    (ireset),
        .bus       (bus),
        .oFL_ADDR  (oFL_ADDR),
        .iFL_DQ    (iFL_DQ),
        .oFL_CE_N  (oFL_CE_N),
        .oFL_OE_N  (oFL_OE_N),
        .oFL_WE_N  (oFL_WE_N),
        .oFL_RST_N (oFL_RST_N),
        .oFL_WP_N  (oFL_WP_N)
    );

    always #5 iclk = ~iclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_q[$];
    int          cyc_q[$];
    logic [22:0] cur_base = 23'd0;
    logic        mon_en   = 1'b0;
    logic        last_ack = 1'b0;
    logic [15:0] last_data = 16'd0;

    always @(posedge iclk) cyc <= cyc + 1;

    // Flash content: a few fixed bytes, everything else a fixed hash of the address.
    function automatic logic [7:0] fl_byte(input logic [22:0] a);
        case (a)
            23'h000100: return 8'hAB;
            23'h000101: return 8'hCD;
            23'h7FFFFE: return 8'h12;
            23'h7FFFFF: return 8'h34;
            default:    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input logic [22:0] a);
        logic [22:0] even;
        even = a - 23'(a % 2);
`ifdef FLASH_BYTE_SWAP_EN
        return {fl_byte(even + 23'd1), fl_byte(even)};
`else
        return {fl_byte(even), fl_byte(even + 23'd1)};
`endif
    endfunction

    always_comb begin
        iFL_DQ = 8'hFF;
        if (!oFL_CE_N && !oFL_OE_N) iFL_DQ = fl_byte(oFL_ADDR);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: static pins, address legality, data hold, scoreboard pop on ack.
    always @(negedge iclk) begin
        if (mon_en) begin
            check("we_n_high", 32'(oFL_WE_N), 32'd1);
            check("wp_n_high", 32'(oFL_WP_N), 32'd1);
            if (!oFL_CE_N) check("addr_word", 32'(oFL_ADDR[22:1]), 32'(cur_base[22:1]));
            if (bus.ofl_ack !== last_ack) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ack_spurious: got ack %0b with no request outstanding", bus.ofl_ack);
                end else begin
                    check("read_data", 32'(bus.ofl_data), 32'(exp_q.pop_front()));
                    check("ack_latency", 32'(cyc - cyc_q.pop_front()), 32'(OBS_LAT));
                end
                last_ack  = bus.ofl_ack;
                last_data = bus.ofl_data;
            end else begin
                check("data_hold", 32'(bus.ofl_data), 32'(last_data));
            end
        end
    end

    task automatic issue(input logic [22:0] a);
        exp_q.push_back(exp_word(a));
        cyc_q.push_back(cyc);
        cur_base    = a - 23'(a % 2);
        bus.ifl_addr = a;
        bus.ifl_req  = ~bus.ifl_req;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.ofl_ack !== bus.ifl_req && n < 200) begin
            @(negedge iclk);
            n++;
            // Address changes while busy must not disturb the latched request.
            if ($urandom_range(0, 3) == 0) bus.ifl_addr = 23'($urandom);
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: no ack after %0d cycles, required within %0d", n, OBS_LAT);
        end
    endtask

    task automatic read(input logic [22:0] a);
        issue(a);
        wait_done();
    endtask

    // Called on a negedge with ireset high; releases it and measures the hold.
    task automatic measure_hold(input string name);
        int n = 0;
        int ce_act = 0;
        ireset = 1'b0;
        while (oFL_RST_N === 1'b0 && n < 1000) begin
            if (oFL_CE_N !== 1'b1 || oFL_OE_N !== 1'b1) ce_act++;
            n++;
            @(negedge iclk);
        end
        check({name, "_rst_n_len"}, 32'(n), 32'(HOLD));
        check({name, "_ce_quiet"}, 32'(ce_act), 32'd0);
        check({name, "_ack_zero"}, 32'(bus.ofl_ack), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ifl_addr = 23'd0;
        bus.ifl_req  = 1'b0;
        ireset       = 1'b1;
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        check("rst_ack",   32'(bus.ofl_ack),  32'd0);
        check("rst_data",  32'(bus.ofl_data), 32'd0);
        check("rst_addr",  32'(oFL_ADDR),     32'd0);
        check("rst_ce_n",  32'(oFL_CE_N),     32'd1);
        check("rst_oe_n",  32'(oFL_OE_N),     32'd1);
        check("rst_we_n",  32'(oFL_WE_N),     32'd1);
        check("rst_rst_n", 32'(oFL_RST_N),    32'd0);
        check("rst_wp_n",  32'(oFL_WP_N),     32'd1);
        measure_hold("init");
        check("idle_ce_n", 32'(oFL_CE_N), 32'd1);
        last_ack  = bus.ofl_ack;
        last_data = bus.ofl_data;
        mon_en    = 1'b1;

        // Directed reads: basic, odd address, top of the address space.
        read(23'h000100);
        read(23'h000101);
        read(23'h7FFFFE);
        read(23'h7FFFFF);

        // Randomized reads with random gaps (gap 0 is back-to-back).
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge iclk);
            read(23'($urandom));
        end

        // Make sure ack is high so a reset-forced zero is observable.
        if (bus.ofl_ack === 1'b0) read(23'($urandom));

        // Abort during the odd-byte access.
        issue(23'($urandom));
        begin
            int n = 0;
            while (!(oFL_CE_N === 1'b0 && oFL_ADDR[0] === 1'b1) && n < 100) begin
                @(negedge iclk);
                n++;
            end
            check("reach_acc_lo", 32'(n < 100), 32'd1);
        end
        @(negedge iclk);
        mon_en = 1'b0;
        ireset = 1'b1;
        bus.ifl_req = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        @(negedge iclk);
        check("abort_ce_n",  32'(oFL_CE_N),     32'd1);
        check("abort_oe_n",  32'(oFL_OE_N),     32'd1);
        check("abort_ack",   32'(bus.ofl_ack),  32'd0);
        check("abort_data",  32'(bus.ofl_data), 32'd0);
        check("abort_rst_n", 32'(oFL_RST_N),    32'd0);
        check("abort_addr",  32'(oFL_ADDR),     32'd0);
        measure_hold("rehold");
        last_ack  = bus.ofl_ack;
        last_data = bus.ofl_data;
        mon_en    = 1'b1;

        read(23'h000100);
        for (int i = 0; i < 4; i++) read(23'($urandom));

        repeat (3) @(negedge iclk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_word_reader.md
FLASH_WORD_READER -- requirements
Module: flash_word_reader

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 6, clocks per flash byte access (legal 2..15).
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 32, clocks oFL_RST_N held low after reset release (legal 1..255).
REQ-003 SHALL have port iclk, in, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port ireset, in, 1: synchronous, active-high reset.
REQ-005 SHALL have port ifl_addr, in, 23: byte address of word; bit 0 ignored, forced 0.
REQ-006 SHALL have port ifl_req, in, 1: toggle request; new request when ifl_req != ofl_ack.
REQ-007 SHALL have port ofl_ack, out, 1: toggle acknowledge; equal to ifl_req once word is valid.
REQ-008 SHALL have port ofl_data, out, 16: read word, held until next completion.
REQ-009 SHALL have port oFL_ADDR, out, 23: flash byte address pins.
REQ-010 SHALL have port iFL_DQ, in, 8: flash data pins (byte mode).
REQ-011 SHALL have ports oFL_CE_N, oFL_OE_N, oFL_WE_N, oFL_RST_N, oFL_WP_N, out, 1 each: active-low flash controls.

Function
REQ-012 SHALL implement states RST_HOLD, IDLE, ACC_HI, ACC_LO, DONE.
- RST_HOLD: oFL_RST_N=0; counter runs RST_HOLD_CYCLES, then IDLE; requests stay pending.
- IDLE: on ifl_req != ofl_ack, latch {ifl_addr[22:1],0} and ifl_req, enter ACC_HI.
- ACC_HI: oFL_ADDR=addr, CE_N=OE_N=0 for ACCESS_CYCLES clocks; on last clock sample iFL_DQ into ofl_data[15:8] staging, enter ACC_LO.
- ACC_LO: oFL_ADDR=addr|1, CE_N=OE_N=0 for ACCESS_CYCLES clocks; sample low byte on last clock, enter DONE.
- DONE: load ofl_data with assembled word; set ofl_ack to latched req in the same edge; CE_N=OE_N=1; return to IDLE.
REQ-013 SHALL make ofl_data valid no later than the edge at which ofl_ack changes, and stable until the next DONE.
REQ-014 SHALL toggle ofl_ack exactly 2*ACCESS_CYCLES+2 clocks after the IDLE edge that detects a request (14 at default).
REQ-015 SHALL place byte at even address in ofl_data[15:8] and odd byte in [7:0] (big-endian).
REQ-016 SHALL sample ifl_req only in IDLE; req changes while busy wait for IDLE.
REQ-017 SHALL hold oFL_WE_N=1 and oFL_WP_N=1 at all times; no write path exists.
REQ-018 SHALL accept address 0x7FFFFE without wrap: reads bytes 0x7FFFFE and 0x7FFFFF.
REQ-019 SHALL service back-to-back requests with one idle cycle between DONE and next ACC_HI.

Reset
REQ-020 SHALL on ireset set: state RST_HOLD, ofl_ack=0, ofl_data=0, oFL_ADDR=0, CE_N=OE_N=WE_N=1, RST_N=0, WP_N=1.
REQ-021 SHALL abort any access when ireset asserts mid-operation; the flash is deselected at that edge and no ack is issued.
REQ-022 SHALL restart the RST_HOLD count from zero on every ireset assertion.

Configuration
REQ-023 SHALL, with FLASH_BYTE_SWAP_EN defined, place even byte in ofl_data[7:0] and odd byte in [15:8]; without it, behave per REQ-015.

Structure
REQ-024 SHALL take state encoding, FL_ADDR_W=23, and default ACCESS_CYCLES/RST_HOLD_CYCLES from shared package flash_pkg.
REQ-025 SHALL be a single module with no sub-module; counters are inline.

Verification
REQ-026 SHALL test reset release: oFL_RST_N low for exactly 32 clocks, ofl_ack=0, and no CE_N activity before IDLE.
REQ-027 SHALL test a single read: model bytes 0x100=0xAB, 0x101=0xCD, ifl_addr=0x000100, toggle req -> ack toggles after 14 clocks, ofl_data=0xABCD.
REQ-028 SHALL test an odd address: ifl_addr=0x000101 -> same result as 0x000100.
REQ-029 SHALL test the top address: ifl_addr=0x7FFFFE with bytes 0x12, 0x34 -> ofl_data=0x1234; oFL_ADDR never exceeds 0x7FFFFF.
REQ-030 SHALL test mid-access reset: assert ireset during ACC_LO -> CE_N=OE_N=1 the next clock, ofl_ack=0, ofl_data=0, RST_HOLD re-entered.
REQ-031 SHALL test a byte-swap build: with FLASH_BYTE_SWAP_EN and the REQ-027 stimulus -> ofl_data=0xCDAB.
